// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch/decode controller between the instruction-pointer stage, the
//   program ROM and the execute stage. It issues one ROM read per
//   instruction, waits (with a timeout) for the ROM to answer, and latches
//   the returned word into opcode/flags/operand. It then holds the
//   instruction valid until execute reports completion, and finally
//   strobes the pointer stage to advance, branch or jump.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   instruction_pointer  program address sampled in the REQ cycle
//   rom_data, rom_valid  ROM read response
//   exec_done            execute stage finished the current instruction
//   rom_req, rom_addr    ROM read request and address
//   instr_valid          opcode/flags/operand valid (EXEC state)
//   opcode/flags/operand latched instruction fields
//   enable               one-cycle pointer advance strobe
//   branch_select        conditional-branch qualifier (opcode 1)
//   atc_out              unconditional-jump request (opcode 2)
//   address              branch/jump target (mirrors operand)
//   fetch_error          sticky ROM timeout flag
//   halted               FSM parked in HALT
module instruction_fetch #(
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         instruction_pointer,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               rom_valid,
  input  logic               exec_done,
  output logic               rom_req,
  output logic [7:0]         rom_addr,
  output logic               instr_valid,
  output logic [3:0]         opcode,
  output logic [3:0]         flags,
  output logic [7:0]         operand,
  output logic               enable,
  output logic               branch_select,
  output logic               atc_out,
  output logic [7:0]         address,
  output logic               fetch_error,
  output logic               halted
);

  // state   | meaning
  // IDLE    | one cycle after reset release
  // REQ     | ROM request, sample pointer, clear timeout
  // WAIT    | waiting for rom_valid, counting timeout
  // EXEC    | instruction valid until exec_done
  // ADVANCE | pointer strobe (advance / branch / jump)
  // HALT    | terminal until reset (opcode F or timeout)
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_EXEC, S_ADVANCE, S_HALT
  } state_t;

  // Timeout fires on the WAIT cycle whose increment would reach TIMEOUT,
  // so a word arriving on that same cycle still wins.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] addr_q;
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      addr_q      <= 8'h00;
      tmo_cnt     <= 8'h00;
      opcode      <= 4'h0;
      flags       <= 4'h0;
      operand     <= 8'h00;
      fetch_error <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_REQ: begin
          addr_q  <= instruction_pointer;
          tmo_cnt <= 8'h00;
        end
        S_WAIT: begin
          if (rom_valid) begin
            opcode  <= rom_data[15:12];
            flags   <= rom_data[11:8];
            operand <= rom_data[7:0];
          end else if (tmo_cnt == TMO_LAST) begin
            fetch_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    rom_req       = 1'b0;
    rom_addr      = addr_q;
    instr_valid   = 1'b0;
    enable        = 1'b0;
    branch_select = 1'b0;
    atc_out       = 1'b0;
    halted        = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        // Present the live pointer in the request cycle; addr_q holds it after.
        rom_req   = 1'b1;
        rom_addr  = instruction_pointer;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rom_valid)                 state_nxt = S_EXEC;
        else if (tmo_cnt == TMO_LAST)  state_nxt = S_HALT;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) state_nxt = (opcode == 4'hF) ? S_HALT : S_ADVANCE;
      end
      S_ADVANCE: begin
        enable        = 1'b1;
        branch_select = (opcode == 4'h1);
        atc_out       = (opcode == 4'h2);
        state_nxt     = S_REQ;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign address = operand;

endmodule
